// File: rtl/audio_pkg.sv
// Shared definitions for the audio AGC path: controller FSM states and the
// gain-index to audio_thr one-hot map (also used by register-bank readback).
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_HOLD    = 2'd3
    } agc_state_e;

    localparam int unsigned GAIN_IDX_MAX = 4;

    // Index 4 maps to the >>8 tap; out-of-range indices fall back to it so
    // the word stays one-hot.
    function automatic logic [4:0] gain_onehot(input logic [2:0] idx);
        logic [4:0] oh;
        case (idx)
            3'd0:    oh = 5'b10000;
            3'd1:    oh = 5'b01000;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b00010;
            default: oh = 5'b00001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/audio_agc_ctrl.sv
// Closed-loop gain/squelch controller: steps the audio block attenuation from
// the windowed power word, with hold-off against hunting and a squelch mute.
module audio_agc_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned POW_WIDTH  = 32,
    parameter int unsigned HOLD_WIDTH = 16,
    parameter int unsigned SQ_CNT     = 4,
    parameter int unsigned INIT_IDX   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  en,
    input  logic [POW_WIDTH-1:0]  power,
    input  logic                  pow_stb,
    input  logic [POW_WIDTH-1:0]  thr_hi,
    input  logic [POW_WIDTH-1:0]  thr_lo,
    input  logic [POW_WIDTH-1:0]  sq_thr,
    input  logic [HOLD_WIDTH-1:0] hold_len,
    output logic [30:0]           audio_thr,
    output logic [2:0]            gain_idx,
    output logic                  mute,
    output logic                  gain_chg
);

    localparam logic [2:0] IDX_INIT = 3'(INIT_IDX);
    localparam logic [2:0] IDX_MAX  = 3'(GAIN_IDX_MAX);
    localparam logic [3:0] SQ_TGT   = 4'(SQ_CNT);

    agc_state_e            state_q, state_d;
    logic [POW_WIDTH-1:0]  p_reg_q, p_reg_d;
    logic [2:0]            idx_q, idx_d;
    logic [4:0]            thr_q, thr_d;
    logic                  mute_q, mute_d;
    logic                  chg_q, chg_d;
    logic [3:0]            sq_cnt_q, sq_cnt_d;
    logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_WIDTH-1:0] hold_inc;

    assign hold_inc = hold_cnt_q + 1'b1;

    // Squelch: runs on every strobe while enabled, whatever the FSM state.
    always_comb begin
        sq_cnt_d = sq_cnt_q;
        mute_d   = mute_q;
        if (!en) begin
            sq_cnt_d = '0;
            mute_d   = 1'b0;
        end else if (pow_stb) begin
            if (power < sq_thr) begin
                if (sq_cnt_q != 4'hF) begin
                    sq_cnt_d = sq_cnt_q + 4'd1;
                end
                mute_d = mute_q | (sq_cnt_d >= SQ_TGT);
            end else begin
                sq_cnt_d = '0;
                mute_d   = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        p_reg_d    = p_reg_q;
        idx_d      = idx_q;
        chg_d      = 1'b0;
        hold_cnt_d = hold_cnt_q;
        if (!en) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (pow_stb) begin
                        p_reg_d = power;
                        state_d = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    // thr_hi takes priority even when already saturated at max,
                    // so a conflicting thr_lo never pulls the index down.
                    if (p_reg_q > thr_hi) begin
                        if (idx_q != IDX_MAX) begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else if (p_reg_q < thr_lo) begin
                        if (idx_q != 3'd0) begin
                            idx_d = idx_q - 3'd1;
                        end
                    end
                    state_d = ST_MEASURE;
                    if (idx_d != idx_q) begin
                        chg_d = 1'b1;
                        if (hold_len != '0) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (pow_stb) begin
                        if (hold_inc == hold_len) begin
                            state_d    = ST_MEASURE;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign thr_d = gain_onehot(idx_d);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            p_reg_q    <= '0;
            idx_q      <= IDX_INIT;
            thr_q      <= gain_onehot(IDX_INIT);
            mute_q     <= 1'b0;
            chg_q      <= 1'b0;
            sq_cnt_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            p_reg_q    <= p_reg_d;
            idx_q      <= idx_d;
            thr_q      <= thr_d;
            mute_q     <= mute_d;
            chg_q      <= chg_d;
            sq_cnt_q   <= sq_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign audio_thr = {26'd0, thr_q};
    assign gain_idx  = idx_q;
    assign mute      = mute_q;
    assign gain_chg  = chg_q;

endmodule
